// File: rtl/lfsr_gen_if.sv
// Bus bundle for lfsr_gen: step/load controls towards the generator, register view and status back.
// The generator sits on the slave modport; whoever drives en/load/seed uses master.
interface lfsr_gen_if #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic             out;
    logic [WIDTH-1:0] state;
    logic             lockup;
    logic             period_done;
    logic [CNT_W-1:0] step_cnt;

    modport master (
        output en, load, seed,
        input  out, state, lockup, period_done, step_cnt
    );

    modport slave (
        input  en, load, seed,
        output out, state, lockup, period_done, step_cnt
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised LFSR (Fibonacci-XNOR or Galois-XOR) with seed load, lock-up escape,
// and a period detector that flags every return of the register to its anchor value.
module lfsr_gen #(
    parameter int               WIDTH        = 10,
    parameter logic [WIDTH-1:0] TAPS         = 10'h240,
    parameter int               MODE         = 0,
    parameter logic [WIDTH-1:0] RESET_SEED   = '0,
    parameter bit               RECOVER      = 1'b1,
    parameter logic [WIDTH-1:0] RECOVER_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               CNT_W        = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    lfsr_gen_if.slave bus
);

    localparam logic [WIDTH-1:0] LOCK_VAL = (MODE == 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    // Configurations that can never leave (or never reach) a useful sequence are rejected up front.
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_gen: WIDTH must be in 2..32");
        end
        if (MODE != 0 && MODE != 1) begin : g_bad_mode
            $error("lfsr_gen: MODE must be 0 (Fibonacci XNOR) or 1 (Galois XOR)");
        end
        if (RESET_SEED == LOCK_VAL) begin : g_bad_reset_seed
            $error("lfsr_gen: RESET_SEED equals the lock value");
        end
        if (RECOVER_SEED == LOCK_VAL) begin : g_bad_recover_seed
            $error("lfsr_gen: RECOVER_SEED equals the lock value");
        end
        if (MODE == 1 && TAPS[0] == 1'b0) begin : g_bad_galois_taps
            $error("lfsr_gen: Galois mode needs TAPS bit 0 set");
        end
    endgenerate

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_RECOVER,
        ACT_STUCK,
        ACT_STEP
    } action_e;

    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] v_shift;
        v_shift = {q[WIDTH-2:0], 1'b0};
        if (MODE == 0) begin
            return {q[WIDTH-2:0], ~^(q & TAPS)};
        end
        return v_shift ^ (q[WIDTH-1] ? TAPS : {WIDTH{1'b0}});
    endfunction

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_anchor;
    logic [CNT_W-1:0] r_cnt;
    logic             r_period_done;

    action_e          w_action;
    logic             w_lockup;
    logic [WIDTH-1:0] w_step;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_anchor_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_period_done_nxt;

    assign w_lockup  = (r_q == LOCK_VAL);
    assign w_step    = f_step(r_q);
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Load beats everything; an enabled step on the lock value either escapes or sticks.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_action = ACT_HOLD;
        if (bus.load) begin
            w_action = ACT_LOAD;
        end else if (bus.en && w_lockup) begin
            w_action = RECOVER ? ACT_RECOVER : ACT_STUCK;
        end else if (bus.en) begin
            w_action = ACT_STEP;
        end
    end

    always_comb begin
        w_q_nxt           = r_q;
        w_anchor_nxt      = r_anchor;
        w_cnt_nxt         = r_cnt;
        w_period_done_nxt = 1'b0;
        case (w_action)
            ACT_LOAD: begin
                w_q_nxt      = bus.seed;
                w_anchor_nxt = bus.seed;
                w_cnt_nxt    = '0;
            end
            ACT_RECOVER: begin
                w_q_nxt      = RECOVER_SEED;
                w_anchor_nxt = RECOVER_SEED;
                w_cnt_nxt    = '0;
            end
            ACT_STUCK: begin
                w_cnt_nxt         = w_cnt_inc;
                w_period_done_nxt = (r_q == r_anchor);
            end
            ACT_STEP: begin
                w_q_nxt           = w_step;
                w_cnt_nxt         = w_cnt_inc;
                w_period_done_nxt = (w_step == r_anchor);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            r_q           <= RESET_SEED;
            r_anchor      <= RESET_SEED;
            r_cnt         <= '0;
            r_period_done <= 1'b0;
        end else begin
            r_q           <= w_q_nxt;
            r_anchor      <= w_anchor_nxt;
            r_cnt         <= w_cnt_nxt;
            r_period_done <= w_period_done_nxt;
        end
    end

    assign bus.out         = r_q[WIDTH-1];
    assign bus.state       = r_q;
    assign bus.lockup      = w_lockup;
    assign bus.period_done = r_period_done;
    assign bus.step_cnt    = r_cnt;

    // A period pulse is only ever raised in the cycle the register sits on its anchor.
    a_period_on_anchor : assert property (
        @(posedge clk) disable iff (!reset_n) r_period_done |-> (r_q == r_anchor)
    );

    a_recover_escapes : assert property (
        @(posedge clk) disable iff (!reset_n)
        (RECOVER && w_lockup && bus.en && !bus.load) |=> !w_lockup
    );

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised successor to the fixed 10-bit XNOR shift-register generator.
- Configurable width, tap mask and topology (Fibonacci-XNOR or Galois-XOR).
- Adds seed load, step enable, lock-up detection/recovery and period detection with a step counter.
- Used as the pseudo-random source for lab stimulus and game logic; also self-checks its own maximal-length period.

Parameters:
WIDTH, 10, register width (2..32)
TAPS, 10'h240, feedback tap mask, bit i = tap on q[i]; default is x^10+x^7+1 in Fibonacci form
MODE, 0, 0 = Fibonacci XNOR, 1 = Galois XOR
RESET_SEED, 0, register value after reset; must not equal the lock value (checked by elaboration assertion)
RECOVER, 1, 1 = auto-escape lock-up on next enabled step; 0 = stay locked
RECOVER_SEED, 1, value loaded on recovery; must not equal the lock value
CNT_W, 16, step counter width

Ports:
clk  in  1  clock, all state on posedge
reset_n  in  1  asynchronous active-low reset
en  in  1  advance one step this cycle
load  in  1  load seed this cycle; priority over en
seed  in  WIDTH  value captured on load
out  out  1  serial output, always q[WIDTH-1]
state  out  WIDTH  current register q
lockup  out  1  combinational, q == lock value
period_done  out  1  registered one-cycle pulse, q returned to anchor
step_cnt  out  CNT_W  steps since last load/reset, saturating

Behaviour:
- Lock value: all-ones for MODE 0, all-zeros for MODE 1.
- MODE 0 step: q <= {q[WIDTH-2:0], fb} with fb = XNOR-reduce(q & TAPS).
- MODE 1 step: q <= (q << 1) ^ (q[WIDTH-1] ? TAPS : 0). TAPS bit 0 must be set (assertion).
- Reset (async assert, sync release):
  - q = RESET_SEED, anchor = RESET_SEED.
  - step_cnt = 0, period_done = 0.
  - out = RESET_SEED[WIDTH-1].
- Per-cycle priority:
  - reset_n low: hold reset values.
  - load = 1: q <= seed, anchor <= seed, step_cnt <= 0, period_done <= 0. en is ignored; no step is taken.
  - en = 1 and lockup = 1 and RECOVER = 1: q <= RECOVER_SEED, anchor <= RECOVER_SEED, step_cnt <= 0, period_done <= 0 (the recovery cycle is not counted as a step).
  - en = 1 and lockup = 1 and RECOVER = 0: q holds (a step maps the lock value to itself); step_cnt increments; period_done pulses every enabled cycle, because next q == anchor only if anchor is the lock value; otherwise period_done = 0.
  - en = 1 otherwise:
    - q <= next(q).
    - step_cnt <= step_cnt + 1, saturating at all-ones (no wrap).
    - period_done <= (next(q) == anchor).
    - When period_done is set, step_cnt is NOT cleared, so the bench reads the period length from it.
  - en = 0: all state holds; period_done <= 0.
- Latency: state, out and lockup reflect a step or load on the cycle after the enabling edge. period_done is high during the same cycle that state first equals anchor.
- Loading the lock value is legal: lockup asserts the next cycle, and recovery follows per RECOVER.
- Reset mid-run: immediate asynchronous return to reset values, regardless of en/load.

Test Plan:
- Default params, reset_n low then high, en=0 for 5 cycles -> state = 10'h000, out = 0, step_cnt = 0, lockup = 0, period_done = 0 throughout.
- Default params, en=1 continuously from reset -> first steps give state 10'h001, 10'h003, 10'h007. period_done pulses exactly once after 1023 steps with step_cnt = 1023 and state = 10'h000, and again at 2046.
- load=1 with seed=10'h155 and en=1 simultaneously -> next state = 10'h155, step_cnt = 0. Then en=1 for 1023 cycles -> period_done with state = 10'h155.
- MODE 0, load 10'h3FF -> lockup = 1. RECOVER=1: next en gives state = 10'h001, lockup = 0, step_cnt = 0. RECOVER=0 variant: state stays 10'h3FF while en=1.
- MODE=1, TAPS=10'h081, RESET_SEED=1, en=1 -> period_done after 1023 steps. Loading 10'h000 asserts lockup, and recovery then loads RECOVER_SEED.
- CNT_W=4, default LFSR, en=1 for 40 cycles -> step_cnt saturates at 15 and holds. Drive reset_n low mid-run -> state = 10'h000 and step_cnt = 0 before the next clock edge.
